relay_bank_driver: RTL and testbench
====================================

Name: relay_bank_driver

Overview:
Drives a bank of NUM_RELAYS dual-coil latching relays (impedance/current selection) from a valid/ready command interface. It generates one fixed-width coil pulse per command, and only one coil is ever energised at a time to limit supply current. A mandatory dead gap separates consecutive pulses. A shadow register tracks each relay's latched position so redundant commands are skipped; it sits between the control/command decoder and the relay driver transistors.

Parameters:
NUM_RELAYS, 2, number of latching relays (each has a set coil and a reset coil); 1..16
IDX_W, 4, width of req_idx; 2^IDX_W >= NUM_RELAYS
PULSE_CYCLES, 32767, coil-on duration in clk cycles (1.48 ms @ 22.1184 MHz); >= 1
GAP_CYCLES, 2212, all-coils-off dead time after each pulse (~100 us); 0 allowed
CNT_W, 16, timer width; PULSE_CYCLES and GAP_CYCLES must be < 2^CNT_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  command present
req_ready  out  1  driver can accept a command this cycle
req_idx  in  IDX_W  relay index
req_state  in  1  1 = latch to set position (set coil), 0 = reset position (reset coil)
req_force  in  1  pulse even if shadow says relay is already in req_state
coil_set  out  NUM_RELAYS  set-coil drive, one bit per relay
coil_rst  out  NUM_RELAYS  reset-coil drive, one bit per relay
busy  out  1  FSM not in IDLE
done  out  1  one-cycle strobe: command completed (pulsed, skipped or rejected)
skipped  out  1  qualifies done: no pulse issued, shadow already matched
err  out  1  qualifies done: req_idx >= NUM_RELAYS, command rejected
relay_state  out  NUM_RELAYS  shadow latched position
state_valid  out  NUM_RELAYS  shadow bit known

Behaviour:
- Reset (sampled on clk edge): FSM=IDLE; coil_set=coil_rst=0; busy=done=skipped=err=0; timer=0; relay_state=0; state_valid=0; req_ready=1 from the first cycle after reset deasserts.
- FSM states: IDLE, PULSE, GAP.
- req_ready = (state==IDLE) && !reset; a command is accepted on a clk edge where req_valid && req_ready.
- Acceptance in IDLE is decoded in priority order:
  - Out of range: req_idx >= NUM_RELAYS -> stay IDLE; next cycle done=1, err=1; no coil activity; shadow unchanged.
  - Skip: state_valid[idx] && relay_state[idx]==req_state && !req_force -> stay IDLE; next cycle done=1, skipped=1.
  - Otherwise: latch idx/state, go to PULSE, load timer.
- PULSE: exactly one bit high, coil_set[idx] if state=1 else coil_rst[idx]. It is high for exactly PULSE_CYCLES consecutive cycles, starting the cycle after acceptance. Coil outputs are registered and glitch-free.
- End of PULSE: relay_state[idx]<=state and state_valid[idx]<=1, both on the final PULSE edge.
  - GAP_CYCLES>0: enter GAP, all coils 0 for exactly GAP_CYCLES cycles, then IDLE.
  - GAP_CYCLES==0: go to IDLE directly.
- done is a one-cycle strobe on the first IDLE cycle after a pulsed command; skipped=err=0 there.
- done, skipped and err are all registered and zero except on their strobe cycle.
- Back-to-back: with req_valid held high, the next command is accepted on the first IDLE cycle (same cycle as the previous done). Pulse-to-pulse spacing is therefore PULSE_CYCLES+GAP_CYCLES+1 cycles.
- Invariant: at no cycle are two coil bits high, nor coil_set[i] and coil_rst[i] together.
- Reset mid-PULSE/GAP: all coils 0 on the cycle after reset is sampled. All shadow state_valid are cleared, since the relay may be half-switched. The interrupted command produces no done.
- Inputs other than req_valid are ignored while req_ready=0; req_idx and req_state are don't-care when req_valid=0.

Test Plan:
- Reset then req idx=0, state=1 (PULSE_CYCLES=8, GAP_CYCLES=3 in bench) -> coil_set[0] high exactly 8 cycles starting cycle+1; all coils 0 for 3 cycles; done=1 next cycle; relay_state[0]=1, state_valid[0]=1.
- Repeat idx=0, state=1, force=0 -> no coil activity; done=1, skipped=1 one cycle after acceptance; req_ready stays 1. Same with force=1 -> full 8-cycle coil_set[0] pulse.
- req_valid held high with idx=1 state=0 then idx=0 state=0 -> coil_rst[1] pulse, 3-cycle gap, coil_rst[0] pulse. Pulse rising edges are 12 cycles apart; never two coils high.
- req_idx=5 with NUM_RELAYS=2 -> done=1, err=1; no coil activity; shadow unchanged.
- Assert reset in cycle 4 of a pulse -> coils 0 next cycle; state_valid=0; no done. A following identical command pulses, not skipped.
- GAP_CYCLES=0 build, two back-to-back commands -> second pulse starts 1 cycle after the first ends (done/accept cycle); coil bits never overlap.

Source files
------------

// File: rtl/relay_bank_driver.sv
// Latching-relay coil sequencer: one coil pulse per accepted command, followed by a dead gap.
// A shadow register of latched positions lets redundant commands complete without a pulse.
module relay_bank_driver #(
  parameter int unsigned NUM_RELAYS   = 2,
  parameter int unsigned IDX_W        = 4,
  parameter int unsigned PULSE_CYCLES = 32767,
  parameter int unsigned GAP_CYCLES   = 2212,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [IDX_W-1:0]      req_idx,
  input  logic                  req_state,
  input  logic                  req_force,
  output logic [NUM_RELAYS-1:0] coil_set,
  output logic [NUM_RELAYS-1:0] coil_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  skipped,
  output logic                  err,
  output logic [NUM_RELAYS-1:0] relay_state,
  output logic [NUM_RELAYS-1:0] state_valid
);

  localparam int unsigned NR = NUM_RELAYS;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_e;

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;
  logic [NR-1:0]    r_sel, w_sel_nxt;
  logic             r_lvl, w_lvl_nxt;
  logic [NR-1:0]    r_coil_set, w_coil_set_nxt;
  logic [NR-1:0]    r_coil_rst, w_coil_rst_nxt;
  logic             r_busy, r_done, w_done_nxt;
  logic             r_skip, w_skip_nxt;
  logic             r_err, w_err_nxt;
  logic [NR-1:0]    r_rs, w_rs_nxt;
  logic [NR-1:0]    r_sv, w_sv_nxt;

  logic             w_idx_ok;
  logic [NR-1:0]    w_sel;
  logic             w_hit;

  // One-hot select avoids indexing the shadow with an out-of-range request index
  assign w_idx_ok = (32'(req_idx) < NR);
  assign w_sel    = NR'(1) << req_idx;
  assign w_hit    = |(w_sel & r_sv & ~(r_rs ^ {NR{req_state}}));

  assign req_ready = (r_state == S_IDLE) && !reset;

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_sel_nxt      = r_sel;
    w_lvl_nxt      = r_lvl;
    w_coil_set_nxt = '0;
    w_coil_rst_nxt = '0;
    w_done_nxt     = 1'b0;
    w_skip_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_rs_nxt       = r_rs;
    w_sv_nxt       = r_sv;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (!w_idx_ok) begin
            w_done_nxt = 1'b1;
            w_err_nxt  = 1'b1;
          end else if (w_hit && !req_force) begin
            w_done_nxt = 1'b1;
            w_skip_nxt = 1'b1;
          end else begin
            w_state_nxt    = S_PULSE;
            w_timer_nxt    = PULSE_LOAD;
            w_sel_nxt      = w_sel;
            w_lvl_nxt      = req_state;
            w_coil_set_nxt = req_state ? w_sel : '0;
            w_coil_rst_nxt = req_state ? '0 : w_sel;
          end
        end
      end
      S_PULSE: begin
        if (r_timer == '0) begin
          w_rs_nxt = (r_rs & ~r_sel) | (r_lvl ? r_sel : '0);
          w_sv_nxt = r_sv | r_sel;
          if (GAP_CYCLES > 0) begin
            w_state_nxt = S_GAP;
            w_timer_nxt = GAP_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_timer_nxt    = r_timer - CNT_W'(1);
          w_coil_set_nxt = r_lvl ? r_sel : '0;
          w_coil_rst_nxt = r_lvl ? '0 : r_sel;
        end
      end
      S_GAP: begin
        if (r_timer == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reset also drops shadow validity: an interrupted pulse may leave a relay half-switched
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_sel      <= '0;
      r_lvl      <= 1'b0;
      r_coil_set <= '0;
      r_coil_rst <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_skip     <= 1'b0;
      r_err      <= 1'b0;
      r_rs       <= '0;
      r_sv       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_sel      <= w_sel_nxt;
      r_lvl      <= w_lvl_nxt;
      r_coil_set <= w_coil_set_nxt;
      r_coil_rst <= w_coil_rst_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
      r_skip     <= w_skip_nxt;
      r_err      <= w_err_nxt;
      r_rs       <= w_rs_nxt;
      r_sv       <= w_sv_nxt;
    end
  end

  assign coil_set    = r_coil_set;
  assign coil_rst    = r_coil_rst;
  assign busy        = r_busy;
  assign done        = r_done;
  assign skipped     = r_skip;
  assign err         = r_err;
  assign relay_state = r_rs;
  assign state_valid = r_sv;

endmodule

// File: tb/tb_relay_bank_driver.sv
// Bench for relay_bank_driver: a gapped build and a zero-gap build share stimulus and are
// compared cycle by cycle against a timestamp-based command model.
module tb_relay_bank_driver;

  localparam int unsigned NR = 2;
  localparam int unsigned IW = 4;
  localparam int unsigned P  = 8;
  localparam int unsigned G0 = 3;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic reset, req_valid, req_state, req_force;
  logic [IW-1:0] req_idx;

  logic rdy0, bz0, dn0, sk0, er0, rdy1, bz1, dn1, sk1, er1;
  logic [NR-1:0] cs0, cr0, rs0, sv0, cs1, cr1, rs1, sv1;

  always #5 clk = ~clk;

  relay_bank_driver #(.NUM_RELAYS(NR), .IDX_W(IW), .PULSE_CYCLES(P), .GAP_CYCLES(G0), .CNT_W(CW)) u_dut_gap (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy0), .req_idx(req_idx),
    .req_state(req_state), .req_force(req_force), .coil_set(cs0), .coil_rst(cr0), .busy(bz0),
    .done(dn0), .skipped(sk0), .err(er0), .relay_state(rs0), .state_valid(sv0));

  relay_bank_driver #(.NUM_RELAYS(NR), .IDX_W(IW), .PULSE_CYCLES(P), .GAP_CYCLES(0), .CNT_W(CW)) u_dut_nogap (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1), .req_idx(req_idx),
    .req_state(req_state), .req_force(req_force), .coil_set(cs1), .coil_rst(cr1), .busy(bz1),
    .done(dn1), .skipped(sk1), .err(er1), .relay_state(rs1), .state_valid(sv1));

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Model: each command is a set of absolute cycle windows (pulse, shadow update, done, free)
  int            m_free [2];
  int            m_ps   [2];
  int            m_pe   [2];
  int            m_sh   [2];
  int            m_done [2];
  int            m_kind [2];
  logic [IW-1:0] m_sidx [2];
  logic          m_lvl  [2];
  logic [NR-1:0] m_rs   [2];
  logic [NR-1:0] m_sv   [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
  endtask

  function automatic int gap_of(input int k);
    return (k == 0) ? int'(G0) : 0;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_free[k] = cyc + 1; m_ps[k] = -10; m_pe[k] = -10; m_sh[k] = -10; m_done[k] = -10;
        m_rs[k] = '0; m_sv[k] = '0;
      end else if (req_valid && cyc >= m_free[k]) begin
        if (32'(req_idx) >= NR) begin
          m_done[k] = cyc + 1; m_kind[k] = 2;
        end else if (1'(m_sv[k] >> req_idx) && (1'(m_rs[k] >> req_idx) == req_state) && !req_force) begin
          m_done[k] = cyc + 1; m_kind[k] = 1;
        end else begin
          m_ps[k]   = cyc + 1;
          m_pe[k]   = cyc + int'(P);
          m_sh[k]   = cyc + int'(P) + 1;
          m_done[k] = cyc + int'(P) + gap_of(k) + 1;
          m_free[k] = m_done[k];
          m_kind[k] = 0;
          m_sidx[k] = req_idx;
          m_lvl[k]  = req_state;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [NR-1:0] mask, es, er;
    logic d;
    for (int k = 0; k < 2; k++) begin
      if (cyc == m_sh[k]) begin
        mask = NR'(1) << m_sidx[k];
        m_rs[k] = (m_rs[k] & ~mask) | (m_lvl[k] ? mask : '0);
        m_sv[k] = m_sv[k] | mask;
      end
      es = '0; er = '0;
      if (cyc >= m_ps[k] && cyc <= m_pe[k]) begin
        mask = NR'(1) << m_sidx[k];
        if (m_lvl[k]) es = mask; else er = mask;
      end
      d = (cyc == m_done[k]);
      chk((k == 0) ? "coil_set" : "coil_set_g0", 32'((k == 0) ? cs0 : cs1), 32'(es));
      chk((k == 0) ? "coil_rst" : "coil_rst_g0", 32'((k == 0) ? cr0 : cr1), 32'(er));
      chk((k == 0) ? "busy" : "busy_g0", 32'((k == 0) ? bz0 : bz1), 32'(cyc < m_free[k]));
      chk((k == 0) ? "done" : "done_g0", 32'((k == 0) ? dn0 : dn1), 32'(d));
      chk((k == 0) ? "skipped" : "skipped_g0", 32'((k == 0) ? sk0 : sk1), 32'(d && m_kind[k] == 1));
      chk((k == 0) ? "err" : "err_g0", 32'((k == 0) ? er0 : er1), 32'(d && m_kind[k] == 2));
      chk((k == 0) ? "relay_state" : "relay_state_g0", 32'((k == 0) ? rs0 : rs1), 32'(m_rs[k]));
      chk((k == 0) ? "state_valid" : "state_valid_g0", 32'((k == 0) ? sv0 : sv1), 32'(m_sv[k]));
    end
  endtask

  task automatic step(input logic v, input logic [IW-1:0] idx, input logic lvl, input logic frc, input logic rst);
    req_valid = v; req_idx = idx; req_state = lvl; req_force = frc; reset = rst;
    #1;
    chk("req_ready", 32'(rdy0), 32'((cyc >= m_free[0]) && !rst));
    chk("req_ready_g0", 32'(rdy1), 32'((cyc >= m_free[1]) && !rst));
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Holds the command valid until the gapped build accepts it
  task automatic send(input logic [IW-1:0] idx, input logic lvl, input logic frc);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = (cyc >= m_free[0]);
      step(1'b1, idx, lvl, frc, 1'b0);
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'(1));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_free[k] = 0; m_ps[k] = -10; m_pe[k] = -10; m_sh[k] = -10; m_done[k] = -10;
      m_kind[k] = 0; m_sidx[k] = '0; m_lvl[k] = 1'b0; m_rs[k] = '0; m_sv[k] = '0;
    end
    req_valid = 1'b0; req_idx = '0; req_state = 1'b0; req_force = 1'b0; reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    send(4'd0, 1'b1, 1'b0); idle(14);
    send(4'd0, 1'b1, 1'b0); idle(2);
    send(4'd0, 1'b1, 1'b1); idle(14);
    send(4'd1, 1'b0, 1'b0); send(4'd0, 1'b0, 1'b0); idle(14);
    send(4'd5, 1'b0, 1'b0); idle(2);
    send(4'd0, 1'b1, 1'b1); idle(3);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(3);
    send(4'd0, 1'b1, 1'b0); idle(14);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), IW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
    end
    idle(14);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
